// File: rtl/vga_in_capture.sv
// vga_in_capture: rebuilds the 24-bit pixel stream from DDR-captured halves,
// normalises sync polarity, measures active geometry and tracks timing lock.
module vga_in_capture #(
    parameter int CNT_BITS       = 12,
    parameter int LOCK_FRAMES    = 2,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         vin_data_h,
    input  logic [11:0]         vin_data_l,
    input  logic                vin_hs,
    input  logic                vin_vs,
    input  logic                vin_de,
    output logic [23:0]         vid_rgb,
    output logic                vid_hs,
    output logic                vid_vs,
    output logic                vid_de,
    output logic                hs_pol,
    output logic                vs_pol,
    output logic [CNT_BITS-1:0] active_width,
    output logic [CNT_BITS-1:0] active_height,
    output logic                locked
);

    localparam int LB = $clog2(LOCK_FRAMES + 1);
    localparam int WB = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [LB-1:0]       LOCK_MAX = LB'(LOCK_FRAMES);
    localparam logic [WB-1:0]       WD_MAX   = WB'(TIMEOUT_CYCLES);

    // stage 1
    logic [11:0] h1_q, h1_d, l1_q, l1_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
    // stage 2 / outputs
    logic [23:0] rgb_q, rgb_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    logic        hs_pol_q, hs_pol_d, vs_pol_q, vs_pol_d;
    // measurement
    logic                vsn_prev_q, vsn_prev_d;
    logic [CNT_BITS-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_BITS-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_BITS-1:0] ref_w_q, ref_w_d;
    logic                frame_bad_q, frame_bad_d;
    logic [CNT_BITS-1:0] prev_w_q, prev_w_d, prev_h_q, prev_h_d;
    logic [CNT_BITS-1:0] act_w_q, act_w_d, act_h_q, act_h_d;
    logic [LB-1:0]       lock_cnt_q, lock_cnt_d;
    logic                locked_q, locked_d;
    logic                sync_seen_q, sync_seen_d;
    logic [WB-1:0]       wd_cnt_q, wd_cnt_d;

    // intermediates: line update applied before frame evaluation
    logic                vsn, boundary, de_fall, valid, match;
    logic [CNT_BITS-1:0] lc_n, rw_n;
    logic                bad_n;

    // Two-stage datapath and polarity learning from the level seen during DE.
    always_comb begin
        h1_d     = vin_data_h;
        l1_d     = vin_data_l;
        hs1_d    = vin_hs;
        vs1_d    = vin_vs;
        de1_d    = vin_de;
        rgb_d    = {l1_q, h1_q};
        de2_d    = de1_q;
        hs2_d    = hs1_q ^ ~hs_pol_q;
        vs2_d    = vs1_q ^ ~vs_pol_q;
        hs_pol_d = hs_pol_q;
        vs_pol_d = vs_pol_q;
        if (de1_q) begin
            hs_pol_d = ~hs1_q;
            vs_pol_d = ~vs1_q;
        end
    end

    // Line/frame measurement, lock tracking and VS watchdog.
    always_comb begin
        vsn      = vs1_q ^ ~vs_pol_q;
        boundary = vsn & ~vsn_prev_q;
        de_fall  = de2_q & ~de1_q;   // de2_q is last cycle's de1

        vsn_prev_d = vsn;
        pix_cnt_d  = '0;
        if (de1_q)
            pix_cnt_d = (pix_cnt_q == CNT_MAX) ? CNT_MAX : pix_cnt_q + 1'b1;

        lc_n  = line_cnt_q;
        rw_n  = ref_w_q;
        bad_n = frame_bad_q;
        if (de_fall) begin
            if (line_cnt_q == '0)
                rw_n = pix_cnt_q;
            else if (pix_cnt_q != ref_w_q)
                bad_n = 1'b1;
            lc_n = (line_cnt_q == CNT_MAX) ? CNT_MAX : line_cnt_q + 1'b1;
        end

        // a frame only counts if it started at a boundary seen since reset
        valid = sync_seen_q && (lc_n != '0) && (rw_n != '0) && !bad_n;
        match = (rw_n == prev_w_q) && (lc_n == prev_h_q);

        line_cnt_d  = lc_n;
        ref_w_d     = rw_n;
        frame_bad_d = bad_n;
        prev_w_d    = prev_w_q;
        prev_h_d    = prev_h_q;
        act_w_d     = act_w_q;
        act_h_d     = act_h_q;
        lock_cnt_d  = lock_cnt_q;
        sync_seen_d = sync_seen_q;

        if (boundary) begin
            sync_seen_d = 1'b1;
            if (valid) begin
                act_w_d  = rw_n;
                act_h_d  = lc_n;
                prev_w_d = rw_n;
                prev_h_d = lc_n;
                if (match)
                    lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 1'b1;
                else
                    lock_cnt_d = LB'(1);
            end else begin
                lock_cnt_d = '0;
            end
            line_cnt_d  = '0;
            ref_w_d     = '0;
            frame_bad_d = 1'b0;
        end

        if (boundary)
            wd_cnt_d = '0;
        else
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + 1'b1;
        if (wd_cnt_d == WD_MAX)
            lock_cnt_d = '0;

        locked_d = (lock_cnt_d == LOCK_MAX);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            h1_q <= '0; l1_q <= '0; hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0;
            rgb_q <= '0; hs2_q <= 1'b0; vs2_q <= 1'b0; de2_q <= 1'b0;
            hs_pol_q <= 1'b0; vs_pol_q <= 1'b0;
            vsn_prev_q  <= 1'b1;  // suppress a false edge from cleared stage-1 regs
            pix_cnt_q   <= '0; line_cnt_q <= '0; ref_w_q <= '0; frame_bad_q <= 1'b0;
            prev_w_q    <= '0; prev_h_q <= '0; act_w_q <= '0; act_h_q <= '0;
            lock_cnt_q  <= '0; locked_q <= 1'b0; sync_seen_q <= 1'b0; wd_cnt_q <= '0;
        end else begin
            h1_q <= h1_d; l1_q <= l1_d; hs1_q <= hs1_d; vs1_q <= vs1_d; de1_q <= de1_d;
            rgb_q <= rgb_d; hs2_q <= hs2_d; vs2_q <= vs2_d; de2_q <= de2_d;
            hs_pol_q <= hs_pol_d; vs_pol_q <= vs_pol_d;
            vsn_prev_q  <= vsn_prev_d;
            pix_cnt_q   <= pix_cnt_d; line_cnt_q <= line_cnt_d; ref_w_q <= ref_w_d;
            frame_bad_q <= frame_bad_d;
            prev_w_q    <= prev_w_d; prev_h_q <= prev_h_d; act_w_q <= act_w_d; act_h_q <= act_h_d;
            lock_cnt_q  <= lock_cnt_d; locked_q <= locked_d; sync_seen_q <= sync_seen_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign vid_rgb       = rgb_q;
    assign vid_hs        = hs2_q;
    assign vid_vs        = vs2_q;
    assign vid_de        = de2_q;
    assign hs_pol        = hs_pol_q;
    assign vs_pol        = vs_pol_q;
    assign active_width  = act_w_q;
    assign active_height = act_h_q;
    assign locked        = locked_q;

endmodule
